// File: rtl/priority_arbiter.sv
// Registered N-way fixed/round-robin priority arbiter with one-hot grant.
// Optional grant locking is compiled in with `define ARB_LOCK_EN.
module priority_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          mode,
    input  logic          lock,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id
);

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } state_e;
`endif

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] last_q, last_d;

    logic [IW-1:0] fix_idx;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_oh;
    int            p;

    // Fixed: ascending scan, so the highest set index is written last.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i[IW-1:0]]) fix_idx = i[IW-1:0];
        end
    end

    // Round-robin order is last-1, last-2, ..., last; scan it backwards
    // so the earliest hit in that order overwrites the rest.
    always_comb begin
        rr_idx = '0;
        p      = 0;
        for (int k = N; k >= 1; k--) begin
            p = int'(last_q) + N - k;
            if (p >= N) p = p - N;
            if (req[p[IW-1:0]]) rr_idx = p[IW-1:0];
        end
    end

    always_comb begin
        win_idx         = mode ? rr_idx : fix_idx;
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

`ifdef ARB_LOCK_EN
    logic hold;
    assign hold = (state_q != IDLE) && lock && req[id_q];
`else
    logic unused_lock;
    assign unused_lock = lock;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = GRANT;
        unique case (1'b1)
            (req == '0): state_d = IDLE;
`ifdef ARB_LOCK_EN
            hold:        state_d = LOCKED;
`endif
            default:     state_d = GRANT;
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        id_d   = id_q;
        last_d = last_q;
        unique case (state_d)
            IDLE: begin
                gnt_d = '0;
                id_d  = '0;
            end
            GRANT: begin
                gnt_d  = win_oh;
                id_d   = win_idx;
                last_d = win_idx;
            end
            default: begin
                gnt_d = gnt_q;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = (state_q != IDLE);

    a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(gnt_q));
    a_valid: assert property (@(posedge clk) disable iff (!reset_n)
        gnt_valid == (|gnt_q));
    a_id_idle: assert property (@(posedge clk) disable iff (!reset_n)
        !gnt_valid |-> (id_q == '0));
    a_id_hit: assert property (@(posedge clk) disable iff (!reset_n)
        gnt_valid |-> gnt_q[id_q]);

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter (N=4): directed plan plus random
// traffic checked against a queue of model-predicted grants.
module tb_priority_arbiter;

    localparam int N = 4;

`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req     = 4'b1111;
    logic       mode    = 1'b0;
    logic       lock    = 1'b0;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;

    priority_arbiter #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .mode      (mode),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag   = 0;
    bit   done  = 1'b0;
    bit   summ  = 1'b0;

    // Reference state: who holds the grant and the rotation pointer.
    bit m_valid = 1'b0;
    int m_id    = 0;
    int m_last  = 0;

    function automatic exp_t mk(input logic [3:0] g, input int t);
        exp_t e;
        e.g   = g;
        e.v   = |g;
        e.id  = 2'd0;
        e.tag = t;
        for (int i = 0; i < 4; i++) if (g[i]) e.id = i[1:0];
        return e;
    endfunction

    function automatic int model_win(input logic [3:0] r, input logic md,
                                     input int last);
        if (!md) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int pos;
                pos = (last - k + 4) % 4;
                if (r[pos]) return pos;
            end
        end
        return 0;
    endfunction

    task automatic push(input logic [3:0] g);
        q.push_back(mk(g, tag));
        tag++;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_last  = 0;
    endtask

    // Called at a falling edge; applies inputs, predicts, waits a cycle.
    task automatic step(input logic [3:0] r, input logic md, input logic lk,
                        input int want);
        logic [3:0] g;
        req  = r;
        mode = md;
        lock = lk;
        if (r == 4'b0000) begin
            m_valid = 1'b0;
            m_id    = 0;
        end else if (!(LOCK_EN && m_valid && lk && r[m_id])) begin
            m_id    = model_win(r, md, m_last);
            m_valid = 1'b1;
            m_last  = m_id;
        end
        g = m_valid ? (4'b0001 << m_id) : 4'b0000;
        if (want >= 0) g = want[3:0];
        push(g);
        @(negedge clk);
    endtask

    task automatic mid_reset();
        push(4'b0000);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (gnt !== e.g || gnt_valid !== e.v || gnt_id !== e.id) begin
                bad++;
                $display("FAIL grant#%0d got gnt=%b v=%b id=%0d want gnt=%b v=%b id=%0d",
                         e.tag, gnt, gnt_valid, gnt_id, e.g, e.v, e.id);
            end
        end
        if (done && !summ) begin
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL drain got %0d pending want 0", q.size());
            end
            summ = 1'b1;
        end
    end

    int fix_r[8] = '{0, 8, 12, 4, 7, 2, 1, 9};
    int fix_g[8] = '{0, 8, 8, 4, 4, 2, 1, 8};
    int rr_g[9]  = '{8, 4, 2, 1, 8, 2, 8, 2, 8};
`ifdef ARB_LOCK_EN
    int lk_g[6]  = '{8, 8, 8, 8, 8, 4};
`else
    int lk_g[6]  = '{4, 2, 1, 8, 4, 2};
`endif

    initial begin
        logic [3:0] r;
        logic       md;
        logic       lk;

        model_reset();
        push(4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        step(4'b1111, 1'b0, 1'b0, 8);

        for (int i = 0; i < 8; i++)
            step(fix_r[i][3:0], 1'b0, 1'b0, fix_g[i]);

        mid_reset();
        for (int i = 0; i < 9; i++)
            step(i < 5 ? 4'b1111 : 4'b1010, 1'b1, 1'b0, rr_g[i]);

        mid_reset();
        step(4'b1111, 1'b1, 1'b0, 8);
        for (int i = 0; i < 5; i++)
            step(4'b1111, 1'b1, 1'b1, lk_g[i]);
        step(4'b0111, 1'b1, 1'b1, lk_g[5]);

        mid_reset();
        step(4'b1111, 1'b1, 1'b0, 8);
        step(4'b1111, 1'b1, 1'b0, 4);
        step(4'b1111, 1'b1, 1'b0, 2);
        mid_reset();
        step(4'b1111, 1'b1, 1'b0, 8);

        step(4'b0000, 1'b1, 1'b1, 0);
        step(4'b0011, 1'b1, 1'b1, -1);

        md = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       r = 4'b0000;
                1:       r = 4'b1111;
                default: r = 4'($urandom);
            endcase
            if ($urandom_range(0, 5) == 0) md = ~md;
            lk = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) mid_reset();
            step(r, md, lk, -1);
        end

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        done = 1'b1;
        for (int i = 0; i < 5 && !summ; i++) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Parametrised, registered N-way priority arbiter: the sequential successor to the 4-bit combinational priority circuit. Samples an N-bit request vector each clock and issues a one-hot grant. The grant uses either fixed priority (highest index wins) or round-robin priority, with optional grant locking. It sits between multiple requesters and a shared resource, such as a memory port or bus, in the ch4 designs.

## Interface
- `N`, default 4: number of requesters; legal range 2..32.
- `IW`, default `$clog2(N)`: width of `gnt_id`; derived, not overridden.

- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in N: request vector; bit i high means requester i wants the resource.
- `mode` in 1: 0 = fixed priority (bit N-1 highest); 1 = round-robin.
- `lock` in 1: hold the current grant (functional only with `ARB_LOCK_EN`).
- `gnt` out N: registered one-hot grant; all-zero when no grant.
- `gnt_valid` out 1: registered; high when `gnt` is non-zero.
- `gnt_id` out IW: registered binary index of the granted bit; 0 when `gnt_valid` is low.

## Operation
- **Reset** (`reset_n` low, any time, asynchronous):
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0.
  - Round-robin pointer `last`=0.
  - State = IDLE.
- **States:**
  - IDLE: no grant outstanding.
  - GRANT: single-cycle grant issued.
  - LOCKED: grant held by lock.
- **Arbitration** (combinational, from `req` and `last`; winner is registered at the clock edge):
  - mode=0: winner = highest set index of `req`. Pure priority-encoder order, identical to the 4-bit priority circuit for N=4.
  - mode=1: search starts at index `last`-1 and descends, wrapping from 0 to N-1. `last` itself is searched last. The first set bit wins.
  - After reset, `last`=0, so the first round-robin search starts at N-1.
- **Transitions** (each clock edge):
  - `req`==0: go to IDLE and clear outputs. This applies from any state.
  - `req`!=0 from IDLE or GRANT: go to GRANT, register the winner, and set `last` = winner index.
  - GRANT or LOCKED, with `lock`=1 and `req[gnt_id]`=1 (`ARB_LOCK_EN` only): go to LOCKED. Grant unchanged, `last` unchanged.
  - LOCKED, with `lock`=0 or `req[gnt_id]`=0: re-arbitrate normally. The next state is GRANT or IDLE.
- **`mode` changes:** take effect at the next arbitration. `last` is retained across mode changes and is updated in both modes.
- **Invariants:**
  - `gnt` is always zero or one-hot.
  - `gnt_valid` = |`gnt`.
  - `gnt_id` is consistent with `gnt`.
- **Unused bits:** request bits at index ≥ N do not exist; no padding logic is required.

## Timing
- Latency is one cycle. `req` sampled at edge k is reflected in `gnt` immediately after edge k.
- The grant drops one cycle after the owner deasserts `req`. There is no combinational path from `req` to `gnt`.
- In round-robin mode with all N bits requesting continuously, each requester is granted exactly once every N cycles.
- Simultaneous `lock` rise and owner `req` fall: `req` takes precedence, so the design re-arbitrates.
- `lock` with no grant outstanding (IDLE) is ignored.
- Reset asserted mid-grant clears outputs without waiting for a clock. Deassertion is synchronous to `clk` at the system level. The first grant occurs at the first edge after release at which `req`!=0.

## Configuration
- Macro: `ARB_LOCK_EN`.
- **Defined:**
  - LOCKED state and `lock` input are active.
  - A locked owner keeps the grant indefinitely while `req[gnt_id]` and `lock` stay high.
- **Undefined:**
  - LOCKED state is not synthesised.
  - The `lock` port still exists but is ignored.
  - Every cycle re-arbitrates, so in round-robin mode a continuous requester cannot hold the resource when others request.

## Test plan
All scenarios use N=4.
- **Reset:** `reset_n`=0 with `req`=4'b1111 → `gnt`=0000, `gnt_valid`=0, `gnt_id`=0. Release, then next edge → `gnt`=1000, `gnt_id`=3.
- **Fixed priority:** mode=0, apply `req` sequence 0000, 1000, 1100, 0100, 0111, 0010, 0001, 1001 over consecutive cycles → `gnt` one cycle later is 0000, 1000, 1000, 0100, 0100, 0010, 0001, 1000.
- **Round-robin rotation:** mode=1, hold `req`=1111 → `gnt` cycles 1000, 0100, 0010, 0001, 1000. Then `req`=1010 → next grants alternate between 0010 and 1000, per the pointer.
- **Lock (`ARB_LOCK_EN` defined):** mode=1, `req`=1111, `lock`=1 after the first grant (1000) → `gnt` stays 1000 for 5 cycles. Drop `req[3]` → next `gnt`=0100.
- **Lock ignored (`ARB_LOCK_EN` undefined):** same stimulus → rotation continues 1000, 0100, 0010.
- **Mid-operation reset:** assert `reset_n`=0 asynchronously between edges while `gnt`=0010 → outputs clear immediately. After release, a round-robin search starts at index 3.
